// File: rtl/bcdgray_arbiter.sv
// Two-requester round-robin front end for a single registered BCD-to-Gray stage.
// The result is held on a valid/ready port tagged with the owner ID until it is accepted.
module bcdgray_arbiter #(
   parameter int unsigned DIGITS = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req0,
   input  logic [4*DIGITS-1:0] bcd0,
   output logic                ack0,
   input  logic                req1,
   input  logic [4*DIGITS-1:0] bcd1,
   output logic                ack1,
   output logic [4*DIGITS-1:0] gray,
   output logic                out_id,
   output logic                out_err,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CNT_W-1:0]    done_cnt
);

   localparam int unsigned W = 4 * DIGITS;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   typedef enum logic [0:0] {StIdle, StOut} state_e;

   state_e           state_q, state_d;
   logic             prio_q, prio_d;
   logic [W-1:0]     gray_q, gray_d;
   logic             id_q, id_d;
   logic             err_q, err_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             grant1;
   logic [W-1:0]     sel_word;

   function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
      logic [W-1:0] g;
      g = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         g[4*i+3] = b[4*i+3];
         g[4*i+2] = b[4*i+3] ^ b[4*i+2];
         g[4*i+1] = b[4*i+2] ^ b[4*i+1];
         g[4*i]   = b[4*i+1] ^ b[4*i];
      end
      return g;
   endfunction

   function automatic logic has_bad_digit(input logic [W-1:0] b);
      logic e;
      e = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         e = e | (b[4*i +: 4] > 4'd9);
      end
      return e;
   endfunction

   // Requester 1 wins when alone, or when both ask and the pointer names it.
   assign grant1   = req1 & (~req0 | prio_q);
   assign sel_word = grant1 ? bcd1 : bcd0;

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      gray_d  = gray_q;
      id_d    = id_q;
      err_d   = err_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               state_d = StOut;
               id_d    = grant1;
               gray_d  = to_gray(sel_word);
               err_d   = has_bad_digit(sel_word);
               ack0_d  = ~grant1;
               ack1_d  = grant1;
            end
         end
         StOut: begin
            if (out_ready) begin
               state_d = StIdle;
               cnt_d   = cnt_q + CntOne;
               prio_d  = ~id_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         prio_q  <= 1'b0;
         gray_q  <= '0;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         gray_q  <= gray_d;
         id_q    <= id_d;
         err_q   <= err_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign gray      = gray_q;
   assign out_id    = id_q;
   assign out_err   = err_q;
   assign out_valid = (state_q == StOut);
   assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_bcdgray_arbiter.sv
// Bench for bcdgray_arbiter: a 1-digit/8-bit-count instance and a 2-digit/2-bit-count
// instance share requests and ready, both compared against a transaction-level model.
module tb_bcdgray_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, out_ready;
   logic [7:0] bcd0w, bcd1w;

   logic       ack0_a, ack1_a, id_a, err_a, valid_a;
   logic [3:0] gray_a;
   logic [7:0] cnt_a;
   logic       ack0_b, ack1_b, id_b, err_b, valid_b;
   logic [7:0] gray_b;
   logic [1:0] cnt_b;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic       busy, owner, exp_ack0, exp_ack1, exp_err_a, exp_err_b;
   logic [7:0] exp_gray;
   int         prio, cnt;

   bcdgray_arbiter #(.DIGITS(1), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .bcd0(bcd0w[3:0]), .ack0(ack0_a),
      .req1(req1), .bcd1(bcd1w[3:0]), .ack1(ack1_a),
      .gray(gray_a), .out_id(id_a), .out_err(err_a), .out_valid(valid_a),
      .out_ready(out_ready), .done_cnt(cnt_a)
   );

   bcdgray_arbiter #(.DIGITS(2), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .bcd0(bcd0w), .ack0(ack0_b),
      .req1(req1), .bcd1(bcd1w), .ack1(ack1_b),
      .gray(gray_b), .out_id(id_b), .out_err(err_b), .out_valid(valid_b),
      .out_ready(out_ready), .done_cnt(cnt_b)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // Reflected binary Gray per decimal digit position, by arithmetic.
   function automatic logic [7:0] ref_gray(input logic [7:0] v);
      int hi, lo;
      hi = int'(v) / 16;
      lo = int'(v) % 16;
      return 8'((hi ^ (hi / 2)) * 16 + (lo ^ (lo / 2)));
   endfunction

   task automatic model_reset();
      busy = 1'b0; owner = 1'b0; exp_ack0 = 1'b0; exp_ack1 = 1'b0;
      exp_err_a = 1'b0; exp_err_b = 1'b0; exp_gray = 8'h00; prio = 0; cnt = 0;
   endtask

   // Predict the effect of the coming clock edge from the current inputs.
   task automatic model_step();
      int w;
      logic [7:0] data;
      exp_ack0 = 1'b0;
      exp_ack1 = 1'b0;
      if (!busy) begin
         if (req0 || req1) begin
            w = (req0 && req1) ? prio : (req1 ? 1 : 0);
            data = (w == 1) ? bcd1w : bcd0w;
            busy = 1'b1;
            owner = (w == 1);
            exp_gray = ref_gray(data);
            exp_err_a = (data[3:0] > 4'd9);
            exp_err_b = (data[3:0] > 4'd9) || (data[7:4] > 4'd9);
            exp_ack0 = (w == 0);
            exp_ack1 = (w == 1);
         end
      end else if (out_ready) begin
         busy = 1'b0;
         cnt = cnt + 1;
         prio = 1 - int'(owner);
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; out_ready = 1'b0;
      bcd0w = 8'h00; bcd1w = 8'h00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({ack0_a, ack1_a, gray_a, id_a, err_a, valid_a, cnt_a} !== 17'd0 ||
          {ack0_b, ack1_b, gray_b, id_b, err_b, valid_b, cnt_b} !== 15'd0) begin
         bad++;
         $display("FAIL reset_outputs got a=%h b=%h want 0",
                  {ack0_a, ack1_a, gray_a, id_a, err_a, valid_a, cnt_a},
                  {ack0_b, ack1_b, gray_b, id_b, err_b, valid_b, cnt_b});
      end
      rst_n = 1'b1;
      repeat (5) cycle();
      total++;
      if (valid_a !== 1'b0 || cnt_a !== 8'd0 || valid_b !== 1'b0 || cnt_b !== 2'd0) begin
         bad++;
         $display("FAIL idle_after_reset got valid=%b cnt=%0d want valid=0 cnt=0",
                  valid_a, cnt_a);
      end
   endtask

   task automatic test_single();
      req0 = 1'b1; bcd0w = 8'h06; out_ready = 1'b1;
      cycle();
      total++;
      if ({ack0_a, ack1_a, valid_a, gray_a, id_a, err_a} !== 9'b1_0_1_0101_0_0 ||
          gray_b !== 8'h05 || err_b !== 1'b0) begin
         bad++;
         $display("FAIL single_capture got ack0=%b ack1=%b v=%b g=%b id=%b e=%b want 1 0 1 0101 0 0",
                  ack0_a, ack1_a, valid_a, gray_a, id_a, err_a);
      end
      req0 = 1'b0;
      cycle();
      total++;
      if (valid_a !== 1'b0 || ack0_a !== 1'b0 || cnt_a !== 8'd1 || cnt_b !== 2'd1) begin
         bad++;
         $display("FAIL single_handshake got v=%b ack0=%b cnt=%0d want 0 0 1",
                  valid_a, ack0_a, cnt_a);
      end
   endtask

   task automatic test_sweep();
      logic [3:0] tbl [10] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110,
                               4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101};
      int start;
      start = cnt;
      out_ready = 1'b1;
      for (int d = 0; d < 10; d++) begin
         req1 = 1'b1;
         bcd1w = 8'(d);
         cycle();
         total++;
         if (ack1_a !== 1'b1 || ack0_a !== 1'b0 || id_a !== 1'b1 || gray_a !== tbl[d] ||
             err_a !== 1'b0 || gray_b !== {4'b0000, tbl[d]}) begin
            bad++;
            $display("FAIL sweep_%0d got ack1=%b id=%b gray=%b want 1 1 %b",
                     d, ack1_a, id_a, gray_a, tbl[d]);
         end
         req1 = 1'b0;
         cycle();
      end
      total++;
      if (cnt_a !== 8'(start + 10)) begin
         bad++;
         $display("FAIL sweep_count got %0d want %0d", cnt_a, start + 10);
      end
   endtask

   task automatic test_contention();
      out_ready = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      bcd0w = 8'($urandom_range(0, 255));
      bcd1w = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) begin
         cycle();
         total++;
         if ((ack0_a && ack1_a) || id_a !== 1'(k % 2) || ack1_a !== 1'(k % 2) ||
             ack0_a !== 1'((k + 1) % 2) || gray_b !== exp_gray) begin
            bad++;
            $display("FAIL contention_%0d got ack0=%b ack1=%b id=%b gray=%h want id=%0d gray=%h",
                     k, ack0_a, ack1_a, id_a, gray_b, k % 2, exp_gray);
         end
         if (k % 2 == 0) req0 = 1'b0; else req1 = 1'b0;
         cycle();
         total++;
         if (valid_a !== 1'b0 || ack0_a !== 1'b0 || ack1_a !== 1'b0) begin
            bad++;
            $display("FAIL contention_hs_%0d got v=%b ack0=%b ack1=%b want 0 0 0",
                     k, valid_a, ack0_a, ack1_a);
         end
         if (k % 2 == 0) begin
            req0 = 1'b1; bcd0w = 8'($urandom_range(0, 255));
         end else begin
            req1 = 1'b1; bcd1w = 8'($urandom_range(0, 255));
         end
      end
      req0 = 1'b0; req1 = 1'b0;
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      req1 = 1'b1; bcd1w = 8'h3B;
      cycle();
      total++;
      if ({ack1_a, valid_a, gray_a, id_a, err_a} !== 8'b1_1_1110_1_1 ||
          gray_b !== 8'h2E || err_b !== 1'b1) begin
         bad++;
         $display("FAIL bp_capture got ack1=%b v=%b g=%b id=%b e=%b gb=%h want 1 1 1110 1 1 2e",
                  ack1_a, valid_a, gray_a, id_a, err_a, gray_b);
      end
      req1 = 1'b0; req0 = 1'b1; bcd0w = 8'h05;
      for (int k = 0; k < 4; k++) begin
         cycle();
         total++;
         if ({ack0_a, ack1_a, valid_a, gray_a, id_a, err_a} !== 9'b0_0_1_1110_1_1) begin
            bad++;
            $display("FAIL bp_hold_%0d got ack0=%b ack1=%b v=%b g=%b id=%b e=%b want 0 0 1 1110 1 1",
                     k, ack0_a, ack1_a, valid_a, gray_a, id_a, err_a);
         end
      end
      out_ready = 1'b1;
      cycle();
      total++;
      if (valid_a !== 1'b0 || cnt_a !== 8'(cnt)) begin
         bad++;
         $display("FAIL bp_release got v=%b cnt=%0d want 0 %0d", valid_a, cnt_a, cnt);
      end
      cycle();
      total++;
      if (ack0_a !== 1'b1 || id_a !== 1'b0 || gray_a !== 4'b0111) begin
         bad++;
         $display("FAIL bp_next got ack0=%b id=%b g=%b want 1 0 0111", ack0_a, id_a, gray_a);
      end
      req0 = 1'b0;
      cycle();
   endtask

   task automatic test_wrap_reset();
      logic [1:0] wrap [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      req0 = 1'b1; bcd0w = 8'h99; out_ready = 1'b0;
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({ack0_a, ack1_a, gray_a, id_a, err_a, valid_a, cnt_a} !== 17'd0 ||
          valid_b !== 1'b0 || cnt_b !== 2'd0) begin
         bad++;
         $display("FAIL async_reset got %h want 0",
                  {ack0_a, ack1_a, gray_a, id_a, err_a, valid_a, cnt_a});
      end
      req0 = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req1 = 1'b1; bcd1w = 8'($urandom_range(0, 255));
         cycle();
         req1 = 1'b0;
         cycle();
         total++;
         if (cnt_b !== wrap[k] || cnt_a !== 8'(k + 1)) begin
            bad++;
            $display("FAIL wrap_%0d got cnt_b=%0d cnt_a=%0d want %0d %0d",
                     k, cnt_b, cnt_a, wrap[k], k + 1);
         end
      end
      req1 = 1'b1; out_ready = 1'b0;
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (valid_a !== 1'b0 || valid_b !== 1'b0 || ack1_a !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_out got v=%b ack1=%b want 0 0", valid_a, ack1_a);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req0 = 1'b1; req1 = 1'b1; bcd0w = 8'h42; bcd1w = 8'h17;
      cycle();
      total++;
      if (ack0_a !== 1'b1 || ack1_a !== 1'b0 || id_a !== 1'b0 || gray_b !== 8'h63) begin
         bad++;
         $display("FAIL post_reset_prio got ack0=%b ack1=%b id=%b gb=%h want 1 0 0 63",
                  ack0_a, ack1_a, id_a, gray_b);
      end
      req0 = 1'b0; req1 = 1'b0; out_ready = 1'b1;
      cycle();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         if (!req0 && $urandom_range(0, 2) == 0) begin
            req0 = 1'b1; bcd0w = 8'($urandom_range(0, 255));
         end
         if (!req1 && $urandom_range(0, 2) == 0) begin
            req1 = 1'b1; bcd1w = 8'($urandom_range(0, 255));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
         total++;
         if ({ack0_a, ack1_a, valid_a, id_a, err_a, gray_a, cnt_a} !==
             {exp_ack0, exp_ack1, busy, owner, exp_err_a, exp_gray[3:0], 8'(cnt)}) begin
            bad++;
            $display("FAIL random_a_%0d got %b want %b", n,
                     {ack0_a, ack1_a, valid_a, id_a, err_a, gray_a, cnt_a},
                     {exp_ack0, exp_ack1, busy, owner, exp_err_a, exp_gray[3:0], 8'(cnt)});
         end
         total++;
         if ({ack0_b, ack1_b, valid_b, id_b, err_b, gray_b, cnt_b} !==
             {exp_ack0, exp_ack1, busy, owner, exp_err_b, exp_gray, 2'(cnt)}) begin
            bad++;
            $display("FAIL random_b_%0d got %b want %b", n,
                     {ack0_b, ack1_b, valid_b, id_b, err_b, gray_b, cnt_b},
                     {exp_ack0, exp_ack1, busy, owner, exp_err_b, exp_gray, 2'(cnt)});
         end
         if (exp_ack0) req0 = 1'b0;
         if (exp_ack1) req1 = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_sweep();
      test_contention();
      test_backpressure();
      test_wrap_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
